// File: rtl/he_mem_pkg.sv
// he_mem_pkg
//   Shared definitions for the HE MEM read path. The window size lives here
//   so the AR window splitter and the bank merger cut at the same boundary.
//   Contents:
//     HE_MEM_WINDOW_LOG2  default bank window (8KB)
//     HE_MEM_BEAT_LOG2    log2 of beat bytes at the default 512-bit bus
//     t_window_beats      beat count within one window, WB inclusive
//     t_split_state       splitter FSM state
package he_mem_pkg;

   localparam int HE_MEM_WINDOW_LOG2 = 13;
   localparam int HE_MEM_BEAT_LOG2   = 6;

   typedef logic [HE_MEM_WINDOW_LOG2-HE_MEM_BEAT_LOG2:0] t_window_beats;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SPLIT = 1'b1
   } t_split_state;

endpackage

// File: rtl/fim_rdack_scfifo.sv
// fim_rdack_scfifo
//   Single-clock show-ahead FIFO. rd_data always presents the head entry;
//   writes while full and reads while empty are ignored.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     wr_en, wr_data    push
//     rd_en, rd_data    pop, head entry
//     empty, full       occupancy flags
module fim_rdack_scfifo #(
   parameter int DATA_WIDTH = 1,
   parameter int DEPTH_LOG2 = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic                  full
);

   logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] wptr, rptr;
   logic [DEPTH_LOG2:0]   count;
   logic                  wr_ok, rd_ok;

   assign empty   = (count == '0);
   assign full    = count[DEPTH_LOG2];
   assign wr_ok   = wr_en && !full;
   assign rd_ok   = rd_en && !empty;
   assign rd_data = mem[rptr];

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_ok) wptr <= wptr + 1'b1;
         if (rd_ok) rptr <= rptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/he_mem_ar_window_splitter.sv
// he_mem_ar_window_splitter
//   Cuts INCR full-width AR bursts at 2^WINDOW_LOG2 byte boundaries so the
//   downstream bank merger never sees a burst spanning two banks. On the R
//   path RLAST is masked on every sub-burst but the last one, so the source
//   sees one R stream per original AR.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     s_ar*                     source read-address channel
//     m_ar*                     sink read-address channel (registered)
//     m_r*                      sink read-data channel
//     s_r*                      source read-data channel (combinational)
module he_mem_ar_window_splitter
   import he_mem_pkg::*;
#(
   parameter int ADDR_WIDTH       = 34,
   parameter int DATA_WIDTH       = 512,
   parameter int ID_WIDTH         = 9,
   parameter int USER_WIDTH       = 8,
   parameter int WINDOW_LOG2      = HE_MEM_WINDOW_LOG2,
   parameter int TRACK_DEPTH_LOG2 = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_arvalid,
   output logic                  s_arready,
   input  logic [ADDR_WIDTH-1:0] s_araddr,
   input  logic [7:0]            s_arlen,
   input  logic [ID_WIDTH-1:0]   s_arid,
   input  logic [USER_WIDTH-1:0] s_aruser,
   output logic                  m_arvalid,
   input  logic                  m_arready,
   output logic [ADDR_WIDTH-1:0] m_araddr,
   output logic [7:0]            m_arlen,
   output logic [ID_WIDTH-1:0]   m_arid,
   output logic [USER_WIDTH-1:0] m_aruser,
   input  logic                  m_rvalid,
   output logic                  m_rready,
   input  logic [DATA_WIDTH-1:0] m_rdata,
   input  logic [1:0]            m_rresp,
   input  logic [ID_WIDTH-1:0]   m_rid,
   input  logic [USER_WIDTH-1:0] m_ruser,
   input  logic                  m_rlast,
   output logic                  s_rvalid,
   input  logic                  s_rready,
   output logic [DATA_WIDTH-1:0] s_rdata,
   output logic [1:0]            s_rresp,
   output logic [ID_WIDTH-1:0]   s_rid,
   output logic [USER_WIDTH-1:0] s_ruser,
   output logic                  s_rlast
);

   localparam int BEAT_LOG2 = $clog2(DATA_WIDTH/8);
   localparam int WB_BITS   = WINDOW_LOG2 - BEAT_LOG2 + 1;
   // Counts must hold both WB and a full 256-beat burst length.
   localparam int CW        = (WB_BITS > 9) ? WB_BITS : 9;
   localparam logic [CW-1:0] WB = CW'(1) << (WINDOW_LOG2 - BEAT_LOG2);
   localparam logic [ADDR_WIDTH-1:0] WIN_MASK =
      (ADDR_WIDTH'(1) << WINDOW_LOG2) - ADDR_WIDTH'(1);

   t_split_state            state;
   logic [ADDR_WIDTH-1:0]   cur_addr;
   logic [CW-1:0]           rem;
   logic [ID_WIDTH-1:0]     cur_id;
   logic [USER_WIDTH-1:0]   cur_user;

   // Skid slot behind the m_ar register: lets s_arready depend only on
   // registered state while still sustaining one piece per cycle.
   logic                    sk_valid;
   logic [ADDR_WIDTH-1:0]   sk_addr;
   logic [7:0]              sk_len;
   logic [ID_WIDTH-1:0]     sk_id;
   logic [USER_WIDTH-1:0]   sk_user;

   logic                    track_full, track_empty, head_flag;

   logic                    ar_acc, split_go, emit, out_free;
   logic [CW-1:0]           beat_off, to_bound, total, nx_rem;
   logic [ADDR_WIDTH-1:0]   pc_addr, nx_addr;
   logic [7:0]              pc_len;
   logic [ID_WIDTH-1:0]     pc_id;
   logic [USER_WIDTH-1:0]   pc_user;
   logic                    pc_last;

   always_comb begin
      s_arready = !rst && (state == ST_IDLE) && !sk_valid && !track_full;
      ar_acc    = s_arvalid && s_arready;
      split_go  = !rst && (state == ST_SPLIT) && !sk_valid && !track_full;
      emit      = ar_acc || split_go;
      out_free  = !m_arvalid || m_arready;

      beat_off  = CW'((s_araddr & WIN_MASK) >> BEAT_LOG2);
      to_bound  = WB - beat_off;
      total     = CW'(s_arlen) + CW'(1);

      pc_addr   = s_araddr;
      pc_len    = s_arlen;
      pc_id     = s_arid;
      pc_user   = s_aruser;
      pc_last   = 1'b1;
      nx_addr   = s_araddr + (ADDR_WIDTH'(to_bound) << BEAT_LOG2);
      nx_rem    = total - to_bound;

      if (state == ST_SPLIT) begin
         pc_addr = cur_addr;
         pc_id   = cur_id;
         pc_user = cur_user;
         pc_last = (rem <= WB);
         pc_len  = pc_last ? 8'(rem - CW'(1)) : 8'(WB - CW'(1));
         nx_addr = cur_addr + (ADDR_WIDTH'(WB) << BEAT_LOG2);
         nx_rem  = rem - WB;
      end else if (total > to_bound) begin
         pc_len  = 8'(to_bound - CW'(1));
         pc_last = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         m_arvalid <= 1'b0;
         sk_valid  <= 1'b0;
      end else begin
         if (emit) begin
            // emit implies the skid slot is empty
            if (out_free) begin
               m_arvalid <= 1'b1;
               m_araddr  <= pc_addr;
               m_arlen   <= pc_len;
               m_arid    <= pc_id;
               m_aruser  <= pc_user;
            end else begin
               sk_valid  <= 1'b1;
               sk_addr   <= pc_addr;
               sk_len    <= pc_len;
               sk_id     <= pc_id;
               sk_user   <= pc_user;
            end
         end else if (out_free) begin
            m_arvalid <= sk_valid;
            m_araddr  <= sk_addr;
            m_arlen   <= sk_len;
            m_arid    <= sk_id;
            m_aruser  <= sk_user;
            sk_valid  <= 1'b0;
         end

         if (ar_acc && !pc_last) begin
            state    <= ST_SPLIT;
            cur_addr <= nx_addr;
            rem      <= nx_rem;
            cur_id   <= s_arid;
            cur_user <= s_aruser;
         end else if (split_go) begin
            cur_addr <= nx_addr;
            rem      <= nx_rem;
            if (pc_last) state <= ST_IDLE;
         end
      end
   end

   // One last-flag per emitted piece; head entry decides whether the sink
   // RLAST of the current sub-burst is the source RLAST.
   fim_rdack_scfifo #(
      .DATA_WIDTH (1),
      .DEPTH_LOG2 (TRACK_DEPTH_LOG2)
   ) u_track (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (emit),
      .wr_data (pc_last),
      .rd_en   (m_rvalid && m_rready && m_rlast),
      .rd_data (head_flag),
      .empty   (track_empty),
      .full    (track_full)
   );

   assign m_rready = s_rready;
   assign s_rvalid = m_rvalid;
   assign s_rdata  = m_rdata;
   assign s_rresp  = m_rresp;
   assign s_rid    = m_rid;
   assign s_ruser  = m_ruser;
   assign s_rlast  = m_rlast && head_flag;

   // An R beat with nothing outstanding means the sink broke ordering.
   assert property (@(posedge clk) disable iff (rst) !(m_rvalid && track_empty));

endmodule

// File: tb/tb_he_mem_ar_window_splitter.sv
module tb_he_mem_ar_window_splitter;

   localparam int AW = 34;
   localparam int DW = 512;
   localparam int IW = 9;
   localparam int UW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_arvalid = 1'b0, s_arready;
   logic [AW-1:0] s_araddr = '0;
   logic [7:0]    s_arlen = '0;
   logic [IW-1:0] s_arid = '0;
   logic [UW-1:0] s_aruser = '0;
   logic          m_arvalid, m_arready = 1'b1;
   logic [AW-1:0] m_araddr;
   logic [7:0]    m_arlen;
   logic [IW-1:0] m_arid;
   logic [UW-1:0] m_aruser;
   logic          m_rvalid = 1'b0, m_rready;
   logic [DW-1:0] m_rdata = '0;
   logic [1:0]    m_rresp = '0;
   logic [IW-1:0] m_rid = '0;
   logic [UW-1:0] m_ruser = '0;
   logic          m_rlast = 1'b0;
   logic          s_rvalid, s_rready = 1'b1;
   logic [DW-1:0] s_rdata;
   logic [1:0]    s_rresp;
   logic [IW-1:0] s_rid;
   logic [UW-1:0] s_ruser;
   logic          s_rlast;

   always #5 clk = ~clk;

   he_mem_ar_window_splitter dut (
      .clk(clk), .rst(rst),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
      .s_arlen(s_arlen), .s_arid(s_arid), .s_aruser(s_aruser),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
      .m_arlen(m_arlen), .m_arid(m_arid), .m_aruser(m_aruser),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
      .m_rresp(m_rresp), .m_rid(m_rid), .m_ruser(m_ruser), .m_rlast(m_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
      .s_rresp(s_rresp), .s_rid(s_rid), .s_ruser(s_ruser), .s_rlast(s_rlast)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    len;
      logic [IW-1:0] id;
      logic [UW-1:0] user;
   } ar_t;

   ar_t  exp_ar[$];
   logic exp_last[$];
   int   issued[$];
   int   total = 0;
   int   bad = 0;
   bit   rstall = 0;

   // AR scoreboard: each sink handshake must match the next expected piece.
   always @(negedge clk) begin : ar_mon
      ar_t e;
      if (!rst && m_arvalid && m_arready) begin
         total++;
         if (exp_ar.size() == 0) begin
            bad++;
            $display("FAIL ar_unexpected got addr=%h len=%0d", m_araddr, m_arlen);
         end else begin
            e = exp_ar.pop_front();
            if (m_araddr !== e.addr || m_arlen !== e.len || m_arid !== e.id || m_aruser !== e.user) begin
               bad++;
               $display("FAIL ar_piece got addr=%h len=%0d id=%h user=%h want addr=%h len=%0d id=%h user=%h",
                        m_araddr, m_arlen, m_arid, m_aruser, e.addr, e.len, e.id, e.user);
            end
         end
         issued.push_back(int'(m_arlen));
      end
   end

   // R scoreboard: one expected s_rlast value per source beat.
   always @(negedge clk) begin : r_mon
      logic el;
      if (!rst && m_rvalid && s_rready) begin
         total++;
         if (exp_last.size() == 0) begin
            bad++;
            $display("FAIL r_unexpected s_rlast=%b", s_rlast);
         end else begin
            el = exp_last.pop_front();
            if (s_rlast !== el || s_rvalid !== 1'b1 || s_rdata !== m_rdata || m_rready !== 1'b1) begin
               bad++;
               $display("FAIL r_beat got s_rlast=%b s_rvalid=%b m_rready=%b want s_rlast=%b s_rvalid=1 m_rready=1",
                        s_rlast, s_rvalid, m_rready, el);
            end
         end
      end
   end

   // Reference model: walk the burst beat by beat, starting a new piece at
   // every 8KB boundary.
   task automatic push_req(input logic [AW-1:0] a, input int len,
                           input logic [IW-1:0] id, input logic [UW-1:0] u);
      logic [AW-1:0] cur;
      ar_t p;
      int cnt;
      cur = a;
      cnt = 0;
      for (int b = 0; b <= len; b++) begin
         if (b != 0 && cur[12:0] == 13'd0) begin
            p.len = 8'(cnt - 1);
            exp_ar.push_back(p);
            cnt = 0;
         end
         if (cnt == 0) begin
            p.addr = cur; p.id = id; p.user = u;
         end
         cnt++;
         cur = cur + AW'(64);
         exp_last.push_back(b == len);
      end
      p.len = 8'(cnt - 1);
      exp_ar.push_back(p);
   endtask

   task automatic wait_accept();
      bit hs;
      hs = 0;
      for (int i = 0; i < 400 && !hs; i++) begin
         @(negedge clk);
         hs = s_arready;
         @(posedge clk); #1;
      end
      if (!hs) begin
         total++; bad++;
         $display("FAIL ar_accept_timeout s_arready stayed 0");
      end
   endtask

   task automatic send_ar(input logic [AW-1:0] a, input int len,
                          input logic [IW-1:0] id, input logic [UW-1:0] u);
      push_req(a, len, id, u);
      s_araddr = a; s_arlen = 8'(len); s_arid = id; s_aruser = u;
      s_arvalid = 1'b1;
      wait_accept();
      s_arvalid = 1'b0;
   endtask

   // Sink R model: returns each issued piece in order with RLAST on its end.
   task automatic drain_r(input int npieces);
      int len;
      for (int p = 0; p < npieces; p++) begin
         int w;
         w = 0;
         while (issued.size() == 0 && w < 300) begin
            @(posedge clk); #1; w++;
         end
         if (issued.size() == 0) begin
            total++; bad++;
            $display("FAIL r_piece_timeout got 0 issued pieces want %0d more", npieces - p);
            break;
         end
         len = issued.pop_front();
         for (int b = 0; b <= len; b++) begin
            bit done;
            done = 0;
            m_rvalid = 1'b1;
            m_rdata  = {16{$urandom}};
            m_rlast  = (b == len);
            m_rresp  = 2'(b);
            m_rid    = IW'(p);
            m_ruser  = UW'(b);
            while (!done) begin
               s_rready = rstall ? ($urandom_range(3) != 0) : 1'b1;
               @(negedge clk);
               done = s_rready;
               @(posedge clk); #1;
            end
         end
      end
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      s_rready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      total++;
      if (m_arvalid !== 1'b0 || s_arready !== 1'b0 || s_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL reset_state got m_arvalid=%b s_arready=%b s_rvalid=%b want 0 0 0",
                  m_arvalid, s_arready, s_rvalid);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (s_arready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release got s_arready=%b want 1", s_arready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      send_ar(34'h0, 7, 9'h011, 8'h5a);
      total++;
      if (m_arvalid !== 1'b1 || m_araddr !== 34'h0 || m_arlen !== 8'd7) begin
         bad++;
         $display("FAIL single_latency got m_arvalid=%b addr=%h len=%0d want 1 0 7",
                  m_arvalid, m_araddr, m_arlen);
      end
      drain_r(1);
   endtask

   task automatic test_cross_small();
      send_ar(34'h1FC0, 3, 9'h022, 8'ha5);
      drain_r(2);
   endtask

   task automatic test_cross_long();
      rstall = 1;
      send_ar(34'h1040, 255, 9'h1ff, 8'hc3);
      drain_r(3);
      rstall = 0;
   endtask

   task automatic test_stall();
      m_arready = 1'b0;
      send_ar(34'h3_0000_1040, 255, 9'h033, 8'h77);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if (m_arvalid !== 1'b1 || m_araddr !== 34'h3_0000_1040 || m_arlen !== 8'd62 || s_arready !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold cyc=%0d got vld=%b addr=%h len=%0d s_arready=%b want 1 300001040 62 0",
                     i, m_arvalid, m_araddr, m_arlen, s_arready);
         end
         @(posedge clk); #1;
      end
      m_arready = 1'b1;
      drain_r(3);
   endtask

   task automatic test_back_to_back();
      time t0;
      t0 = $time;
      for (int i = 0; i < 4; i++) send_ar(AW'(i * 'h400), 3, IW'(i), UW'(i + 8));
      total++;
      if ($time - t0 != 40) begin
         bad++;
         $display("FAIL back_to_back got %0t time units want 40", $time - t0);
      end
      drain_r(4);
   endtask

   task automatic test_tracker_full();
      m_arready = 1'b1;
      for (int i = 0; i < 64; i++) send_ar(AW'(i * 64), 0, IW'(i), UW'(i));
      repeat (2) @(posedge clk);
      #1;
      s_araddr = 34'h2000; s_arlen = 8'd0; s_arid = 9'h100; s_aruser = 8'h41;
      s_arvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (s_arready !== 1'b0) begin
            bad++;
            $display("FAIL track_full_block cyc=%0d got s_arready=%b want 0", i, s_arready);
         end
         @(posedge clk); #1;
      end
      s_arvalid = 1'b0;
      drain_r(1);
      send_ar(34'h2000, 0, 9'h100, 8'h41);
      s_araddr = 34'h2040; s_arid = 9'h101; s_aruser = 8'h42;
      s_arvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (s_arready !== 1'b0) begin
            bad++;
            $display("FAIL track_one_more cyc=%0d got s_arready=%b want 0", i, s_arready);
         end
         @(posedge clk); #1;
      end
      s_arvalid = 1'b0;
      drain_r(64);
      send_ar(34'h2040, 0, 9'h101, 8'h42);
      drain_r(1);
   endtask

   task automatic test_reset_mid_split();
      m_arready = 1'b0;
      send_ar(34'h1040, 255, 9'h055, 8'h99);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      total++;
      if (m_arvalid !== 1'b0 || s_arready !== 1'b0) begin
         bad++;
         $display("FAIL rst_split got m_arvalid=%b s_arready=%b want 0 0", m_arvalid, s_arready);
      end
      exp_ar.delete();
      exp_last.delete();
      issued.delete();
      rst = 1'b0;
      m_arready = 1'b1;
      @(negedge clk);
      total++;
      if (s_arready !== 1'b1 || m_arvalid !== 1'b0) begin
         bad++;
         $display("FAIL rst_split_idle got s_arready=%b m_arvalid=%b want 1 0", s_arready, m_arvalid);
      end
      @(posedge clk); #1;
      send_ar(34'h0, 7, 9'h066, 8'h12);
      drain_r(1);
   endtask

   initial begin
      test_reset();
      test_single();
      test_cross_small();
      test_cross_long();
      test_stall();
      test_back_to_back();
      test_tracker_full();
      test_reset_mid_split();
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (exp_ar.size() != 0 || exp_last.size() != 0 || issued.size() != 0) begin
         bad++;
         $display("FAIL leftovers got ar=%0d r=%0d issued=%0d want 0 0 0",
                  exp_ar.size(), exp_last.size(), issued.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
